tone_sequencer: RTL and testbench

Parametrised multi-channel piezo tone generator for the car-simulator sound path. Each of NCH channels generates a square-wave tone with its own divisor and a gating mode (continuous, repeating cadence, or retriggerable one-shot), all set at run time through a small register-write port. A fixed-priority mux drives one registered piezo output. Lower channel index wins (horn = channel 0). The block sits between the vehicle-state logic and the piezo pin.

---
 rtl/sound_pkg.sv | 17 +
 rtl/tone_channel.sv | 112 +++++++++++
 rtl/tone_sequencer.sv | 92 +++++++++
 tb/tb_tone_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: shared encodings for the tone sequencer.
// Channel gating modes and config-register selects.
package sound_pkg;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_CADENCE = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  localparam logic [1:0] SEL_HALF_DIV = 2'd0;
  localparam logic [1:0] SEL_ON_LEN   = 2'd1;
  localparam logic [1:0] SEL_PERIOD   = 2'd2;
  localparam logic [1:0] SEL_MODE     = 2'd3;

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one tone voice with its config registers,
// cadence/burst gating and square-wave divider.
module tone_channel
  import sound_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIV_W  = 20,
  parameter int CAD_W  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [CAD_W-1:0] data,
  output logic             snd,
  output logic             wave
);

  localparam logic [DIV_W-1:0] HALF_RST =
    DIV_W'(CLK_HZ / 2000 - 1);
  localparam logic [CAD_W-1:0] ON_RST =
    CAD_W'(CLK_HZ / 2);
  localparam logic [CAD_W-1:0] PER_RST =
    CAD_W'(CLK_HZ - 1);

  logic [DIV_W-1:0] half_div;
  logic [CAD_W-1:0] on_len;
  logic [CAD_W-1:0] period;
  mode_t            mode;

  logic [CAD_W-1:0] cad_cnt;
  logic [CAD_W-1:0] burst_cnt;
  logic [DIV_W-1:0] tone_cnt;
  logic             wave_q;
  logic [CAD_W-1:0] burst_ld;

  // a trigger coinciding with an ON_LEN write uses the new length
  assign burst_ld = (we && sel == SEL_ON_LEN) ? data : on_len;

  // run-time configuration writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_div <= HALF_RST;
      on_len   <= ON_RST;
      period   <= PER_RST;
      mode     <= MODE_CONT;
    end else if (we) begin
      unique case (1'b1)
        sel == SEL_HALF_DIV: half_div <= data[DIV_W-1:0];
        sel == SEL_ON_LEN:   on_len   <= data;
        sel == SEL_PERIOD:   period   <= data;
        sel == SEL_MODE:     mode     <= mode_t'(data[1:0]);
      endcase
    end
  end

  // gating: decide whether the voice sounds this cycle
  always_comb begin
    snd = 1'b0;
    if (en) begin
      case (mode)
        MODE_CONT:    snd = 1'b1;
        MODE_CADENCE: snd = cad_cnt < on_len;
        MODE_ONESHOT: snd = burst_cnt != '0;
        default:      snd = 1'b0;
      endcase
    end
  end

  // cadence phase and one-shot burst counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cad_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      if (!en || mode != MODE_CADENCE)
        cad_cnt <= '0;
      else if (cad_cnt >= period)
        cad_cnt <= '0;
      else
        cad_cnt <= cad_cnt + CAD_W'(1);

      if (!en || mode != MODE_ONESHOT)
        burst_cnt <= '0;
      else if (trig)
        burst_cnt <= burst_ld;
      else if (burst_cnt != '0)
        burst_cnt <= burst_cnt - CAD_W'(1);
    end
  end

  // square-wave divider, held low while silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      wave_q   <= 1'b0;
    end else if (!snd) begin
      tone_cnt <= '0;
      wave_q   <= 1'b0;
    end else if (tone_cnt >= half_div) begin
      tone_cnt <= '0;
      wave_q   <= ~wave_q;
    end else begin
      tone_cnt <= tone_cnt + DIV_W'(1);
    end
  end

  assign wave = wave_q & snd;

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: NCH tone voices, fixed-priority mux, registered
// piezo output. Define SOUND_VOLUME_EN for the 3-bit PWM volume.
module tone_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int NCH    = 4,
  parameter int DIV_W  = 20,
  parameter int CAD_W  = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH-1:0]         ch_trig,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [1:0]             cfg_sel,
  input  logic [CAD_W-1:0]       cfg_data,
`ifdef SOUND_VOLUME_EN
  input  logic [2:0]             vol,
`endif
  output logic                   piezo_out,
  output logic [$clog2(NCH)-1:0] active_ch,
  output logic                   busy
);

  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]  snd;
  logic [NCH-1:0]  wave;
  logic            pick_wave;
  logic [CH_W-1:0] pick_ch;
  logic            tone_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tone_channel #(
      .CLK_HZ(CLK_HZ),
      .DIV_W (DIV_W),
      .CAD_W (CAD_W)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .en  (ch_en[i]),
      .trig(ch_trig[i]),
      .we  (cfg_we && (cfg_ch == CH_W'(i))),
      .sel (cfg_sel),
      .data(cfg_data),
      .snd (snd[i]),
      .wave(wave[i])
    );
  end

  // lowest-index sounding voice wins
  always_comb begin
    pick_wave = 1'b0;
    pick_ch   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (snd[i]) begin
        pick_wave = wave[i];
        pick_ch   = CH_W'(i);
      end
    end
  end

`ifdef SOUND_VOLUME_EN
  logic [2:0] pwm_cnt;

  // free-running PWM phase for volume chopping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign tone_d = pick_wave & (pwm_cnt < vol);
`else
  assign tone_d = pick_wave;
`endif

  // output register: tone, owner and busy move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piezo_out <= 1'b0;
      active_ch <= '0;
      busy      <= 1'b0;
    end else begin
      piezo_out <= tone_d;
      active_ch <= pick_ch;
      busy      <= |snd;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table-driven, directed and randomized checks
// of tone_sequencer against a cycle-count reference model.
module tb_tone_sequencer;
  import sound_pkg::*;

  localparam int NCH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ch_en = '0;
  logic [2:0] ch_trig = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [25:0] cfg_data = '0;
  logic       piezo_out;
  logic [1:0] active_ch;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SOUND_VOLUME_EN
  logic [2:0] vol = 3'd7;
  logic [2:0] pwm_m;
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_m <= '0;
    else     pwm_m <= pwm_m + 3'd1;
  end
`endif

  tone_sequencer #(
    .CLK_HZ(1_000_000),
    .NCH   (NCH),
    .DIV_W (20),
    .CAD_W (26)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .ch_trig  (ch_trig),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
`ifdef SOUND_VOLUME_EN
    .vol      (vol),
`endif
    .piezo_out(piezo_out),
    .active_ch(active_ch),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; int mode; int hd; int ol; int per;
    bit trig; int n;
    int e_busy; int e_rise; int e_first;
  } case_t;

  case_t tbl[7];

  task automatic check(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_en = '0;
    ch_trig = '0;
    cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cfg_wr(int ch, int sel, int data);
    cfg_we = 1'b1;
    cfg_ch = 2'(ch);
    cfg_sel = 2'(sel);
    cfg_data = 26'(data);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic run_case(int k);
    case_t c;
    int nb, nr, fr, act_bad;
    bit pv;
    c = tbl[k];
    do_reset();
    cfg_wr(c.ch, SEL_HALF_DIV, c.hd);
    cfg_wr(c.ch, SEL_ON_LEN, c.ol);
    cfg_wr(c.ch, SEL_PERIOD, c.per);
    cfg_wr(c.ch, SEL_MODE, c.mode);
    nb = 0; nr = 0; fr = 0; act_bad = 0; pv = 1'b0;
    ch_en[c.ch] = 1'b1;
    ch_trig[c.ch] = c.trig;
    for (int j = 1; j <= c.n; j++) begin
      step();
      ch_trig = '0;
      if (busy) begin
        nb++;
        if (active_ch != 2'(c.ch)) act_bad++;
      end
      if (piezo_out && !pv) begin
        nr++;
        if (fr == 0) fr = j;
      end
      pv = piezo_out;
    end
    ch_en = '0;
    check($sformatf("tbl%0d_busy", k), nb, c.e_busy);
    check($sformatf("tbl%0d_active", k), act_bad, 0);
`ifndef SOUND_VOLUME_EN
    check($sformatf("tbl%0d_rises", k), nr, c.e_rise);
    check($sformatf("tbl%0d_first", k), fr, c.e_first);
`endif
  endtask

  // Reference: each voice is described by how long it has been
  // enabled, when it was last triggered, and how long it has been
  // sounding; wave level follows from integer division.
  task automatic rand_run(int ncyc);
    int md[NCH], hd[NCH], ol[NCH], pd[NCH];
    int age[NCH], run[NCH], lt[NCH];
    bit vld[NCH];
    bit ep, eb, s, w;
    int ea;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      md[i] = $urandom_range(0, 3);
      hd[i] = $urandom_range(0, 5);
      ol[i] = $urandom_range(0, 12);
      pd[i] = $urandom_range(0, 15);
      cfg_wr(i, SEL_HALF_DIV, hd[i]);
      cfg_wr(i, SEL_ON_LEN, ol[i]);
      cfg_wr(i, SEL_PERIOD, pd[i]);
      cfg_wr(i, SEL_MODE, md[i]);
      age[i] = 0; run[i] = 0; lt[i] = 0; vld[i] = 1'b0;
    end
    ep = 1'b0; eb = 1'b0; ea = 0;
    for (int t = 0; t < ncyc; t++) begin
      check("rnd_busy", int'(busy), int'(eb));
      check("rnd_active", int'(active_ch), ea);
      check("rnd_piezo", int'(piezo_out), int'(ep));
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 7) == 0) ch_en[i] = ~ch_en[i];
        ch_trig[i] = ($urandom_range(0, 4) == 0);
      end
      eb = 1'b0; ea = 0; ep = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        s = 1'b0;
        if (ch_en[i]) begin
          case (md[i])
            0: s = 1'b1;
            1: s = (age[i] % (pd[i] + 1)) < ol[i];
            2: s = vld[i] && (t - lt[i]) >= 1 &&
                   (t - lt[i]) <= ol[i];
            default: s = 1'b0;
          endcase
        end
        w = s && ((run[i] / (hd[i] + 1)) % 2 == 1);
        if (s && !eb) begin
          eb = 1'b1; ea = i; ep = w;
        end
        run[i] = s ? run[i] + 1 : 0;
        age[i] = ch_en[i] ? age[i] + 1 : 0;
        if (!ch_en[i]) vld[i] = 1'b0;
        else if (ch_trig[i] && md[i] == 2) begin
          vld[i] = 1'b1;
          lt[i] = t;
        end
      end
`ifdef SOUND_VOLUME_EN
      ep = ep && (pwm_m < vol);
`endif
      step();
    end
    ch_en = '0;
    ch_trig = '0;
  endtask

  initial begin
    int nb, fr;
    bit pv;

    tbl[0] = '{1, 0, 4, 0, 0, 1'b0, 60, 60, 6, 6};
    tbl[1] = '{2, 1, 1, 20, 49, 1'b0, 100, 40, 10, 3};
    tbl[2] = '{0, 2, 2, 10, 0, 1'b1, 30, 10, 2, 5};
    tbl[3] = '{1, 2, 2, 0, 0, 1'b1, 20, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 1'b0, 20, 20, 10, 2};
    tbl[5] = '{2, 3, 1, 5, 9, 1'b1, 20, 0, 0, 0};
    tbl[6] = '{1, 1, 3, 8, 5, 1'b0, 40, 40, 5, 5};

    #2 rst = 1'b1;
    #2;
    check("reset_piezo", int'(piezo_out), 0);
    check("reset_active", int'(active_ch), 0);
    check("reset_busy", int'(busy), 0);

    for (int k = 0; k < 7; k++) run_case(k);

    // retrigger at cycle 6 extends the burst to 16 cycles
    do_reset();
    cfg_wr(1, SEL_HALF_DIV, 9);
    cfg_wr(1, SEL_ON_LEN, 10);
    cfg_wr(1, SEL_MODE, MODE_ONESHOT);
    nb = 0;
    ch_en[1] = 1'b1;
    ch_trig[1] = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      step();
      ch_trig[1] = (j == 6);
      if (busy) nb++;
    end
    check("retrig_len", nb, 16);
    check("retrig_end_busy", int'(busy), 0);
    check("retrig_end_piezo", int'(piezo_out), 0);
    ch_en = '0;

    // ON_LEN write and trigger in the same cycle
    do_reset();
    cfg_wr(0, SEL_HALF_DIV, 1);
    cfg_wr(0, SEL_ON_LEN, 10);
    cfg_wr(0, SEL_MODE, MODE_ONESHOT);
    nb = 0;
    ch_en[0] = 1'b1;
    ch_trig[0] = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0;
    cfg_sel = SEL_ON_LEN; cfg_data = 26'd3;
    for (int j = 1; j <= 15; j++) begin
      step();
      ch_trig = '0;
      cfg_we = 1'b0;
      if (busy) nb++;
    end
    check("wr_trig_len", nb, 3);
    ch_en = '0;

    // preemption by ch0, then ch2 resumes its running phase
    do_reset();
    cfg_wr(2, SEL_HALF_DIV, 4);
    cfg_wr(0, SEL_HALF_DIV, 1);
    ch_en[2] = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 10) ch_en[0] = 1'b1;
      if (j == 14) ch_en[0] = 1'b0;
      if (j == 9) check("prio_pre_active", int'(active_ch), 2);
      if (j == 11) begin
        check("prio_take_active", int'(active_ch), 0);
        check("prio_take_busy", int'(busy), 1);
      end
      if (j == 15) check("prio_back_active", int'(active_ch), 2);
`ifndef SOUND_VOLUME_EN
      if (j == 13) check("prio_ch0_wave", int'(piezo_out), 1);
      if (j == 16) check("prio_ch2_phase", int'(piezo_out), 1);
`endif
    end
    ch_en = '0;

    // reset in the middle of a burst restores defaults
    do_reset();
    cfg_wr(1, SEL_HALF_DIV, 2);
    cfg_wr(1, SEL_ON_LEN, 200);
    cfg_wr(1, SEL_MODE, MODE_ONESHOT);
    ch_en[1] = 1'b1;
    ch_trig[1] = 1'b1;
    step();
    ch_trig = '0;
    repeat (19) step();
    check("rst_pre_busy", int'(busy), 1);
    check("rst_pre_active", int'(active_ch), 1);
    rst = 1'b1;
    ch_en = '0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_active", int'(active_ch), 0);
    check("rst_mid_piezo", int'(piezo_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();
    check("rst_idle_busy", int'(busy), 0);
    ch_en[1] = 1'b1;
    fr = 0;
    pv = 1'b0;
    for (int j = 1; j <= 1200 && fr == 0; j++) begin
      step();
      if (j == 1) check("rst_en_latency", int'(busy), 1);
      if (piezo_out && !pv) fr = j;
      pv = piezo_out;
    end
`ifndef SOUND_VOLUME_EN
    check("rst_default_tone", fr, 501);
`endif
    ch_en = '0;

`ifdef SOUND_VOLUME_EN
    // volume zero mutes an otherwise toggling voice
    do_reset();
    vol = 3'd0;
    cfg_wr(0, SEL_HALF_DIV, 0);
    ch_en[0] = 1'b1;
    nb = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (piezo_out) nb++;
    end
    check("vol0_highs", nb, 0);
    check("vol0_busy", int'(busy), 1);
    ch_en = '0;
    vol = 3'd7;
`endif

    rand_run(400);
    rand_run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
